// File: rtl/dm_arb_if.sv
// Bus bundle between the data-memory arbiter, its two requesters and the memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface dm_arb_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          r0_req;
    logic          r0_we;
    logic [AW-1:0] r0_adr;
    logic [DW-1:0] r0_wdata;
    logic          r0_gnt;
    logic          r0_rvalid;
    logic [DW-1:0] r0_rdata;

    logic          r1_req;
    logic          r1_we;
    logic [AW-1:0] r1_adr;
    logic [DW-1:0] r1_wdata;
    logic          r1_gnt;
    logic          r1_rvalid;
    logic [DW-1:0] r1_rdata;

    logic          dm_en;
    logic          dm_we;
    logic [AW-1:0] dm_adr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          busy;

    modport slave (
        input  r0_req, r0_we, r0_adr, r0_wdata,
        input  r1_req, r1_we, r1_adr, r1_wdata,
        input  dm_rdata,
        output r0_gnt, r0_rvalid, r0_rdata,
        output r1_gnt, r1_rvalid, r1_rdata,
        output dm_en, dm_we, dm_adr, dm_wdata, busy
    );

    modport master (
        output r0_req, r0_we, r0_adr, r0_wdata,
        output r1_req, r1_we, r1_adr, r1_wdata,
        output dm_rdata,
        input  r0_gnt, r0_rvalid, r0_rdata,
        input  r1_gnt, r1_rvalid, r1_rdata,
        input  dm_en, dm_we, dm_adr, dm_wdata, busy
    );
endinterface

// File: rtl/dm_arb.sv
// Round-robin two-port arbiter and single-operation sequencer for a synchronous-read
// data memory; all outputs come straight from registers.
module dm_arb #(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int MEM_LAT = 1
) (
    input  logic     clk,
    input  logic     rst_n,
    dm_arb_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] LAT_M1 = 2'(MEM_LAT - 1);

    state_t        r_state;
    logic          r_owner;
    logic          r_last;
    logic          r_we;
    logic [AW-1:0] r_adr;
    logic [DW-1:0] r_wdata;
    logic [1:0]    r_cnt;
    logic [1:0]    r_gnt;
    logic [1:0]    r_rvalid;
    logic          r_dm_en;
    logic          r_dm_we;
    logic          r_busy;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;
    logic          w_any;
    logic          w_win;

    // r1 wins when alone, or on a tie when r0 was the last winner
    assign w_any = bus.r0_req | bus.r1_req;
    assign w_win = bus.r1_req & (~bus.r0_req | ~r_last);

    // Sequencer state, latched request copy and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_owner  <= 1'b0;
            r_last   <= 1'b1;
            r_we     <= 1'b0;
            r_adr    <= {AW{1'b0}};
            r_wdata  <= {DW{1'b0}};
            r_cnt    <= 2'd0;
            r_gnt    <= 2'b00;
            r_rvalid <= 2'b00;
            r_dm_en  <= 1'b0;
            r_dm_we  <= 1'b0;
            r_busy   <= 1'b0;
            r_rdata0 <= {DW{1'b0}};
            r_rdata1 <= {DW{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_owner <= w_win;
                        r_last  <= w_win;
                        r_we    <= w_win ? bus.r1_we    : bus.r0_we;
                        r_adr   <= w_win ? bus.r1_adr   : bus.r0_adr;
                        r_wdata <= w_win ? bus.r1_wdata : bus.r0_wdata;
                        r_dm_we <= w_win ? bus.r1_we    : bus.r0_we;
                        r_gnt   <= w_win ? 2'b10 : 2'b01;
                        r_dm_en <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_ISSUE;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    r_gnt   <= 2'b00;
                    r_dm_en <= 1'b0;
                    r_dm_we <= 1'b0;
                    if (r_we) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt   <= LAT_M1;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 2'd0) begin
                        if (r_owner) begin
                            r_rdata1 <= bus.dm_rdata;
                        end else begin
                            r_rdata0 <= bus.dm_rdata;
                        end
                        r_rvalid <= r_owner ? 2'b10 : 2'b01;
                        r_state  <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                S_RESP: begin
                    r_rvalid <= 2'b00;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_gnt    <= 2'b00;
                    r_rvalid <= 2'b00;
                    r_dm_en  <= 1'b0;
                    r_dm_we  <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.r0_gnt    = r_gnt[0];
    assign bus.r1_gnt    = r_gnt[1];
    assign bus.r0_rvalid = r_rvalid[0];
    assign bus.r1_rvalid = r_rvalid[1];
    assign bus.r0_rdata  = r_rdata0;
    assign bus.r1_rdata  = r_rdata1;
    assign bus.dm_en     = r_dm_en;
    assign bus.dm_we     = r_dm_we;
    assign bus.dm_adr    = r_adr;
    assign bus.dm_wdata  = r_wdata;
    assign bus.busy      = r_busy;
endmodule

// File: tb/tb_dm_arb.sv
// Bench for dm_arb: two instances (memory latency 1 and 3), each with a memory model,
// a transaction-level reference checked every cycle, directed cases and random traffic.
module tb_dm_arb;
    localparam int AW = 8;
    localparam int DW = 8;

    logic clk = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   done_cnt = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input int lat, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (MEM_LAT=%0d): got 0x%0h, required 0x%0h at %0t", name, lat, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int LAT = (g == 0) ? 1 : 3;

        logic          rst_n;
        logic [DW-1:0] hw_mem [0:255];
        logic [DW-1:0] pipe_d [0:2];
        logic          pipe_v [0:2];
        logic [DW-1:0] junk;
        logic          mem_init = 1'b0;
        int            rv_seen0 = 0;
        int            rv_seen1 = 0;

        dm_arb_if #(.AW(AW), .DW(DW)) bus ();

        dm_arb #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus.slave)
        );

        // Synchronous-read memory: data is valid exactly LAT cycles after the strobe cycle
        always @(posedge clk) begin
            if (!mem_init) begin
                for (int i = 0; i < 256; i++) hw_mem[i] <= 8'(i ^ 32'h5A);
                hw_mem[4] <= 8'h3C;
                for (int i = 0; i < 3; i++) pipe_v[i] <= 1'b0;
                mem_init <= 1'b1;
            end else begin
                if (bus.dm_en && bus.dm_we) hw_mem[bus.dm_adr] <= bus.dm_wdata;
                pipe_v[0] <= bus.dm_en && !bus.dm_we;
                pipe_d[0] <= hw_mem[bus.dm_adr];
                pipe_v[1] <= pipe_v[0];
                pipe_d[1] <= pipe_d[0];
                pipe_v[2] <= pipe_v[1];
                pipe_d[2] <= pipe_d[1];
            end
            junk <= 8'($urandom);
        end
        assign bus.dm_rdata = pipe_v[LAT-1] ? pipe_d[LAT-1] : junk;

        // Reference: schedule of expected outputs derived per accepted request, checked every cycle
        initial begin : model
            logic [7:0] ref_mem [0:255];
            logic [7:0] m_rd [0:1];
            logic [7:0] m_adr, m_wd, m_val;
            logic       m_we;
            int t, free_at, issue_at, rv_at, own, last, w;
            for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i ^ 32'h5A);
            ref_mem[4] = 8'h3C;
            t = 0; free_at = 0; issue_at = -1; rv_at = -1; own = 0; last = 1;
            m_rd[0] = 8'h00; m_rd[1] = 8'h00; m_adr = 8'h00; m_wd = 8'h00; m_val = 8'h00; m_we = 1'b0;
            forever begin
                @(negedge clk);
                t++;
                if (rst_n !== 1'b1) begin
                    free_at = 0; issue_at = -1; rv_at = -1; last = 1;
                    m_rd[0] = 8'h00; m_rd[1] = 8'h00;
                    chk("rst_gnt",    LAT, {bus.r1_gnt, bus.r0_gnt}, 32'd0);
                    chk("rst_rvalid", LAT, {bus.r1_rvalid, bus.r0_rvalid}, 32'd0);
                    chk("rst_rdata",  LAT, {bus.r1_rdata, bus.r0_rdata}, 32'd0);
                    chk("rst_dm",     LAT, {bus.dm_en, bus.dm_we, bus.dm_adr, bus.dm_wdata}, 32'd0);
                    chk("rst_busy",   LAT, bus.busy, 32'd0);
                end else begin
                    if (t == rv_at) m_rd[own] = m_val;
                    chk("r0_gnt",    LAT, bus.r0_gnt,    32'(t == issue_at && own == 0));
                    chk("r1_gnt",    LAT, bus.r1_gnt,    32'(t == issue_at && own == 1));
                    chk("dm_en",     LAT, bus.dm_en,     32'(t == issue_at));
                    if (t == issue_at) begin
                        chk("dm_we",    LAT, bus.dm_we,    32'(m_we));
                        chk("dm_adr",   LAT, bus.dm_adr,   32'(m_adr));
                        chk("dm_wdata", LAT, bus.dm_wdata, 32'(m_wd));
                    end else begin
                        chk("dm_we_idle", LAT, bus.dm_we, 32'd0);
                    end
                    chk("r0_rvalid", LAT, bus.r0_rvalid, 32'(t == rv_at && own == 0));
                    chk("r1_rvalid", LAT, bus.r1_rvalid, 32'(t == rv_at && own == 1));
                    chk("r0_rdata",  LAT, bus.r0_rdata,  32'(m_rd[0]));
                    chk("r1_rdata",  LAT, bus.r1_rdata,  32'(m_rd[1]));
                    chk("busy",      LAT, bus.busy,      32'(t < free_at));
                    if (t >= free_at && (bus.r0_req || bus.r1_req)) begin
                        if (bus.r0_req && bus.r1_req) w = 1 - last;
                        else                          w = bus.r1_req ? 1 : 0;
                        last  = w;
                        own   = w;
                        m_we  = w ? bus.r1_we : bus.r0_we;
                        m_adr = w ? bus.r1_adr : bus.r0_adr;
                        m_wd  = w ? bus.r1_wdata : bus.r0_wdata;
                        issue_at = t + 1;
                        if (m_we) begin
                            ref_mem[m_adr] = m_wd;
                            rv_at = -1;
                            free_at = t + 2;
                        end else begin
                            m_val = ref_mem[m_adr];
                            rv_at = t + LAT + 2;
                            free_at = t + LAT + 3;
                        end
                    end
                end
                if (bus.r0_rvalid === 1'b1) rv_seen0++;
                if (bus.r1_rvalid === 1'b1) rv_seen1++;
            end
        end

        // Directed cases followed by random two-requester traffic
        initial begin : drive
            int rv_cyc, rv_cnt, ng, k0, k1, reads0, reads1;
            logic [7:0] rv_dat;
            int order [0:19];
            logic [7:0] wd0 [0:9];
            logic [7:0] wd1 [0:9];
            rst_n = 1'b0;
            bus.r0_req = 1'b0; bus.r0_we = 1'b0; bus.r0_adr = 8'h00; bus.r0_wdata = 8'h00;
            bus.r1_req = 1'b0; bus.r1_we = 1'b0; bus.r1_adr = 8'h00; bus.r1_wdata = 8'h00;
            for (int i = 0; i < 5; i++) begin
                @(posedge clk); #1;
                bus.r0_req = 1'($urandom); bus.r0_we = 1'($urandom); bus.r0_adr = 8'($urandom);
                bus.r1_req = 1'($urandom); bus.r1_we = 1'($urandom); bus.r1_adr = 8'($urandom);
            end
            @(posedge clk); #1;
            rst_n = 1'b1; bus.r0_req = 1'b0; bus.r1_req = 1'b0;
            for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
            chk("post_rst_quiet", LAT, {bus.busy, bus.dm_en, bus.r0_gnt, bus.r1_gnt}, 32'd0);

            // single r0 write, adr 3 data A5
            bus.r0_req = 1'b1; bus.r0_we = 1'b1; bus.r0_adr = 8'h03; bus.r0_wdata = 8'hA5;
            @(posedge clk); #1;
            chk("wr_c1_gnt_en_we", LAT, {bus.r0_gnt, bus.r1_gnt, bus.dm_en, bus.dm_we}, 32'b1011);
            chk("wr_c1_adr_data",  LAT, {bus.dm_adr, bus.dm_wdata}, 32'h03A5);
            bus.r0_req = 1'b0;
            @(posedge clk); #1;
            chk("wr_c2_busy_rv", LAT, {bus.busy, bus.r0_rvalid, bus.r1_rvalid}, 32'd0);

            // single r1 read, adr 4 holds 3C
            bus.r1_req = 1'b1; bus.r1_we = 1'b0; bus.r1_adr = 8'h04;
            rv_cyc = -1; rv_cnt = 0; rv_dat = 8'h00;
            for (int k = 1; k <= 12; k++) begin
                @(posedge clk); #1;
                if (k == 1) begin
                    chk("rd_c1_gnt", LAT, {bus.r1_gnt, bus.dm_en, bus.dm_we}, 32'b110);
                    bus.r1_req = 1'b0;
                end
                if (bus.r1_rvalid) begin rv_cyc = k; rv_cnt++; rv_dat = bus.r1_rdata; end
            end
            chk("rd_rvalid_cycle", LAT, rv_cyc, LAT + 2);
            chk("rd_rvalid_count", LAT, rv_cnt, 32'd1);
            chk("rd_r1_rdata",     LAT, rv_dat, 32'h3C);
            chk("rd_r0_rdata_kept", LAT, bus.r0_rdata, 32'h00);

            // contention: 10 back-to-back writes per requester
            ng = 0; k0 = 0; k1 = 0;
            for (int i = 0; i < 10; i++) begin wd0[i] = 8'($urandom); wd1[i] = 8'($urandom); end
            bus.r0_req = 1'b1; bus.r0_we = 1'b1; bus.r0_adr = 8'h20; bus.r0_wdata = wd0[0];
            bus.r1_req = 1'b1; bus.r1_we = 1'b1; bus.r1_adr = 8'h40; bus.r1_wdata = wd1[0];
            for (int c = 0; c < 100 && ng < 20; c++) begin
                @(posedge clk); #1;
                chk("no_double_gnt", LAT, 32'(bus.r0_gnt & bus.r1_gnt), 32'd0);
                if (bus.r0_gnt) begin
                    order[ng] = 0; ng++; k0++;
                    if (k0 == 10) bus.r0_req = 1'b0;
                    else begin bus.r0_adr = 8'(32'h20 + k0); bus.r0_wdata = wd0[k0]; end
                end
                if (bus.r1_gnt) begin
                    order[ng] = 1; ng++; k1++;
                    if (k1 == 10) bus.r1_req = 1'b0;
                    else begin bus.r1_adr = 8'(32'h40 + k1); bus.r1_wdata = wd1[k1]; end
                end
            end
            chk("cont_grants", LAT, ng, 32'd20);
            for (int i = 0; i < 20; i++) chk("cont_order", LAT, order[i], i % 2);
            @(posedge clk); #1;
            @(posedge clk); #1;
            for (int i = 0; i < 10; i++) begin
                chk("cont_mem_r0", LAT, hw_mem[8'(32'h20 + i)], 32'(wd0[i]));
                chk("cont_mem_r1", LAT, hw_mem[8'(32'h40 + i)], 32'(wd1[i]));
            end

            // reset during WAIT aborts the read silently
            bus.r0_req = 1'b1; bus.r0_we = 1'b0; bus.r0_adr = 8'h05;
            @(posedge clk); #1;
            chk("abort_gnt", LAT, bus.r0_gnt, 32'd1);
            bus.r0_req = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b0;
            @(posedge clk); #1;
            @(posedge clk); #1;
            rst_n = 1'b1;
            rv_cnt = 0;
            for (int k = 0; k < 10; k++) begin
                @(posedge clk); #1;
                if (bus.r0_rvalid || bus.r1_rvalid) rv_cnt++;
            end
            chk("abort_no_rvalid", LAT, rv_cnt, 32'd0);
            chk("abort_idle", LAT, bus.busy, 32'd0);
            bus.r0_req = 1'b1;
            rv_cyc = -1; rv_dat = 8'h00;
            for (int k = 1; k <= 12; k++) begin
                @(posedge clk); #1;
                if (k == 1) bus.r0_req = 1'b0;
                if (bus.r0_rvalid) begin rv_cyc = k; rv_dat = bus.r0_rdata; end
            end
            chk("reread_cycle", LAT, rv_cyc, LAT + 2);
            chk("reread_data",  LAT, rv_dat, 32'h5F);

            // random traffic, 1000 operations per requester
            reads0 = 0; reads1 = 0;
            fork
                begin
                    int to;
                    for (int n = 0; n < 1000; n++) begin
                        for (int d = $urandom_range(0, 2); d > 0; d--) begin
                            bus.r0_req = 1'b0; @(posedge clk); #1;
                        end
                        bus.r0_req = 1'b1; bus.r0_we = 1'($urandom);
                        bus.r0_adr = 8'($urandom_range(0, 15)); bus.r0_wdata = 8'($urandom);
                        if (!bus.r0_we) reads0++;
                        to = 0;
                        do begin @(posedge clk); #1; to++; end while (!bus.r0_gnt && to < 50);
                        if (!bus.r0_gnt) chk("r0_gnt_timeout", LAT, to, 32'd0);
                    end
                    bus.r0_req = 1'b0;
                end
                begin
                    int to;
                    for (int n = 0; n < 1000; n++) begin
                        for (int d = $urandom_range(0, 2); d > 0; d--) begin
                            bus.r1_req = 1'b0; @(posedge clk); #1;
                        end
                        bus.r1_req = 1'b1; bus.r1_we = 1'($urandom);
                        bus.r1_adr = 8'($urandom_range(0, 15)); bus.r1_wdata = 8'($urandom);
                        if (!bus.r1_we) reads1++;
                        to = 0;
                        do begin @(posedge clk); #1; to++; end while (!bus.r1_gnt && to < 50);
                        if (!bus.r1_gnt) chk("r1_gnt_timeout", LAT, to, 32'd0);
                    end
                    bus.r1_req = 1'b0;
                end
            join
            for (int k = 0; k < 10; k++) begin @(posedge clk); #1; end
            chk("r0_rvalid_total", LAT, rv_seen0, reads0 + 1);
            chk("r1_rvalid_total", LAT, rv_seen1, reads1 + 1);
            done_cnt++;
        end
    end

    initial begin
        for (int i = 0; i < 95000 && done_cnt < 2; i++) @(posedge clk);
        if (done_cnt < 2) chk("run_timeout", 0, done_cnt, 32'd2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dm_arb.md
# dm_arb

Two-port arbiter and access sequencer for the CPU data memory. It shares a single synchronous-read data memory between requester 0 (core load/store path, address from the LDM/STR address select) and requester 1 (program/data loader or debug port). It selects requesters round-robin, drives one memory operation at a time, and returns read data with a one-cycle valid pulse to the requester that issued the read.

## Interface
Parameters:
- AW, 8: address width.
- DW, 8: data width.
- MEM_LAT, 1: memory read latency, in cycles from dm_en to dm_rdata valid. Legal range is 1..3.

Ports:
- clk, in, 1: single clock; all state updates on the rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- r0_req, in, 1: requester 0 access request.
- r0_we, in, 1: requester 0 write (1) / read (0).
- r0_adr, in, AW: requester 0 address.
- r0_wdata, in, DW: requester 0 write data.
- r0_gnt, out, 1: one-cycle grant; the request was accepted and issued this cycle.
- r0_rvalid, out, 1: one-cycle read-data-valid pulse.
- r0_rdata, out, DW: registered read data; holds its value until the next requester 0 read completes.
- r1_req, r1_we, r1_adr, r1_wdata, r1_gnt, r1_rvalid, r1_rdata: same as requester 0, for requester 1.
- dm_en, out, 1: memory access strobe.
- dm_we, out, 1: memory write enable; valid only with dm_en.
- dm_adr, out, AW: memory address.
- dm_wdata, out, DW: memory write data.
- dm_rdata, in, DW: memory read data.
- busy, out, 1: 1 whenever the state is not IDLE.

## Operation
- State machine: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Sample r0_req and r1_req.
  - If neither is set, stay in IDLE.
  - Otherwise pick a winner. Latch its we, adr and wdata plus a 1-bit owner, then go to ISSUE.
- Arbitration:
  - If only one requester is asserting req, it wins.
  - If both are asserting req, the requester that did not win last time wins.
  - The last-winner pointer updates on each grant. Its reset value makes r0 win the first tie.
- ISSUE:
  - Drive dm_en=1 with dm_we, dm_adr and dm_wdata from the latched copy.
  - Pulse gnt to the owner.
  - Write: go to IDLE.
  - Read: load the latency counter with MEM_LAT-1 and go to WAIT.
- WAIT:
  - Counter at 0: capture dm_rdata into the owner's rdata register, then go to RESP.
  - Otherwise decrement the counter.
- RESP: assert rvalid to the owner for one cycle, then go to IDLE.
- dm_en, dm_we and both gnt outputs are 0 in all states other than ISSUE. The dm_adr and dm_wdata values are don't-care when dm_en=0; implement them as the latched copy.
- Requester protocol:
  - req, we, adr and wdata are held stable from assertion until gnt.
  - A req deasserted before it is sampled in IDLE is simply not served.
  - req may stay high after gnt for the next request, and is re-arbitrated at the next IDLE.
- Non-owner rdata is never modified.
- Reset (asynchronous, any state, including mid-read):
  - State goes to IDLE; all outputs go to 0; both rdata registers go to 0; the pointer goes to "r1 last".
  - An in-flight read produces no rvalid. A write already strobed is not undone.

## Timing
- Cycle 0 is the cycle in IDLE where req is sampled at the closing edge.
- Write: gnt and dm_en in cycle 1; IDLE in cycle 2. Throughput is one write per 2 cycles.
- Read: gnt and dm_en in cycle 1; dm_rdata captured at the end of cycle MEM_LAT+1; rvalid in cycle MEM_LAT+2; IDLE in cycle MEM_LAT+3.
  - With MEM_LAT=1: rvalid in cycle 3. Throughput is one read per MEM_LAT+3 cycles.
- req→gnt latency is 1 cycle when the arbiter is in IDLE. Otherwise the request waits until the next IDLE.
- Worst-case wait for a continuously requesting port is one competing access.

## Test plan
- Reset: hold rst_n=0 with random inputs. Required response: all outputs 0, busy=0. Release reset: still 0 until a req arrives.
- Single write: r0 writes adr 3, wdata 0xA5. Required response: cycle 1 has r0_gnt=1, dm_en=1, dm_we=1, dm_adr=3, dm_wdata=0xA5; no rvalid; busy returns to 0 in cycle 2.
- Single read, MEM_LAT=1 and MEM_LAT=3: r1 reads adr 4 while the memory model returns 0x3C. Required response: r1_rvalid in cycle 3 (respectively cycle 5) with r1_rdata=0x3C; r0_rdata unchanged.
- Contention: both requesters hold req continuously.
  - First grant to r0, then grants alternate r1, r0, r1.
  - No cycle ever has two gnts or a gnt with dm_en=0.
  - 10 back-to-back writes by each requester all reach memory in alternating order.
- Reset mid-read: assert rst_n=0 during WAIT. Required response: no rvalid ever appears; state is IDLE; a subsequent r0 read of adr 5 completes normally.
- Random traffic against a memory scoreboard: 2000 mixed operations. Required response: every read returns the last written value for its address; rvalid count equals read count per requester.
